wb_stage: RTL



---
 rtl/wb_stage_if.sv | 56 +++++
 rtl/wb_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if: bundle between the MEM stage, the write-back stage and the
// register-file write port.
//
//   in_valid / in_ready      MEM result handshake (stage accepts on both high)
//   in_opcode, in_func3      instruction opcode and load width/sign selector
//   in_rd                    destination register
//   in_alu_result            ALU result, or load effective address
//   in_mem_rdata             raw aligned doubleword from data memory
//   in_pc                    instruction PC
//   out_valid / out_ready    register-file handshake (entry leaves on both high)
//   wdata, wrd, wopcode      write-back value, register and opcode
//   misalign                 misaligned-load flag (only with WB_MISALIGN_CHK_EN)
//
// Modports: slave = the write-back stage, master = the side that feeds it
// and consumes its write port.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface wb_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_func3;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_mem_rdata;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] wdata;
    logic [4:0]      wrd;
    logic [6:0]      wopcode;
`ifdef WB_MISALIGN_CHK_EN
    logic            misalign;
`endif

    modport slave (
`ifdef WB_MISALIGN_CHK_EN
        output misalign,
`endif
        input  in_valid, in_opcode, in_func3, in_rd,
        input  in_alu_result, in_mem_rdata, in_pc, out_ready,
        output in_ready, out_valid, wdata, wrd, wopcode
    );

    modport master (
`ifdef WB_MISALIGN_CHK_EN
        input  misalign,
`endif
        output in_valid, in_opcode, in_func3, in_rd,
        output in_alu_result, in_mem_rdata, in_pc, out_ready,
        input  in_ready, out_valid, wdata, wrd, wopcode
    );
endinterface

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage: RV64 write-back stage.
//
// Takes retired MEM-stage results, forms the final register write value at
// accept time (load lane extraction + sign/zero extension, PC+4 for jal/jalr,
// ALU result otherwise) and queues it in a small skid FIFO that drains into
// the shared register-file write port, which may back-pressure.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   asynchronous, active-low reset
//   bus   wb_stage_if.slave (input handshake, write-port handshake, data)
//
// Parameters:
//   XLEN  datapath width (64 only)
//   DEPTH skid FIFO entries (power of two, >= 2)
//
// Optional feature macro WB_MISALIGN_CHK_EN: adds the `misalign` output and
// turns misaligned lh/lhu/lw/lwu/ld into register-0 writes flagged misaligned.
// Without it, misaligned loads extract from the shifted lane with zeros
// entering above bit 63.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    wb_stage_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_NOP    = 7'b0010011;

    // Shift the addressed byte down to bit 0, then size and extend per funct3.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] rdata,
        input logic [2:0]      off,
        input logic [2:0]      f3
    );
        logic [XLEN-1:0] lane;
        lane = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_extract = {{(XLEN-8){lane[7]}},   lane[7:0]};
            3'b001:  load_extract = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b010:  load_extract = {{(XLEN-32){lane[31]}}, lane[31:0]};
            3'b011:  load_extract = lane;
            3'b100:  load_extract = {{(XLEN-8){1'b0}},  lane[7:0]};
            3'b101:  load_extract = {{(XLEN-16){1'b0}}, lane[15:0]};
            3'b110:  load_extract = {{(XLEN-32){1'b0}}, lane[31:0]};
            default: load_extract = '0;
        endcase
    endfunction

`ifdef WB_MISALIGN_CHK_EN
    // Natural alignment check; byte loads and funct3=111 can never misalign.
    function automatic logic load_misaligned(
        input logic [2:0] off,
        input logic [2:0] f3
    );
        case (f3[1:0])
            2'b01:   load_misaligned = off[0];
            2'b10:   load_misaligned = |off[1:0];
            2'b11:   load_misaligned = ~f3[2] & (|off);
            default: load_misaligned = 1'b0;
        endcase
    endfunction
`endif

    logic             vld_p0;
    logic [XLEN-1:0]  wb_data_p0;
    logic [4:0]       wb_rd_p0;
`ifdef WB_MISALIGN_CHK_EN
    logic             mis_p0;
`endif

    logic [XLEN-1:0]  mem_data_p1 [DEPTH];
    logic [4:0]       mem_rd_p1   [DEPTH];
    logic [6:0]       mem_op_p1   [DEPTH];
`ifdef WB_MISALIGN_CHK_EN
    logic             mem_mis_p1  [DEPTH];
    logic             last_mis;
`endif
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             in_ready_int;
    logic             vld_p1;
    logic             emit;
    logic [XLEN-1:0]  last_data;
    logic [4:0]       last_rd;
    logic [6:0]       last_op;

    // ---- stage p0: accept and form the write-back value ----
    assign in_ready_int = (count < CNT_W'(DEPTH));
    assign vld_p0       = bus.in_valid & in_ready_int;

    always_comb begin
        wb_data_p0 = bus.in_alu_result;
        wb_rd_p0   = bus.in_rd;
`ifdef WB_MISALIGN_CHK_EN
        mis_p0     = 1'b0;
`endif
        case (bus.in_opcode)
            OP_LOAD: begin
                wb_data_p0 = load_extract(bus.in_mem_rdata, bus.in_alu_result[2:0], bus.in_func3);
`ifdef WB_MISALIGN_CHK_EN
                mis_p0     = load_misaligned(bus.in_alu_result[2:0], bus.in_func3);
`endif
            end
            OP_JAL, OP_JALR: wb_data_p0 = bus.in_pc + XLEN'(4);
            OP_STORE, OP_BRANCH: begin
                wb_data_p0 = '0;
                wb_rd_p0   = '0;
            end
            default: ;
        endcase
        // x0 is never really written, so make the entry harmless downstream.
        if (bus.in_rd == 5'd0) begin
            wb_data_p0 = '0;
            wb_rd_p0   = '0;
        end
`ifdef WB_MISALIGN_CHK_EN
        if (mis_p0) begin
            wb_data_p0 = '0;
            wb_rd_p0   = '0;
        end
`endif
    end

    // ---- stage p1: skid FIFO storage ----
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            mem_data_p1[wr_ptr] <= wb_data_p0;
            mem_rd_p1[wr_ptr]   <= wb_rd_p0;
            mem_op_p1[wr_ptr]   <= bus.in_opcode;
`ifdef WB_MISALIGN_CHK_EN
            mem_mis_p1[wr_ptr]  <= mis_p0;
`endif
        end
    end

    assign vld_p1 = (count != '0);
    assign emit   = vld_p1 & bus.out_ready;

    // Pointers wrap naturally because DEPTH is a power of two. The last_*
    // registers keep the most recently emitted entry so the write port holds
    // its value while the FIFO is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
            last_rd   <= '0;
            last_op   <= OP_NOP;
`ifdef WB_MISALIGN_CHK_EN
            last_mis  <= 1'b0;
`endif
        end else begin
            if (vld_p0) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (emit) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_data <= mem_data_p1[rd_ptr];
                last_rd   <= mem_rd_p1[rd_ptr];
                last_op   <= mem_op_p1[rd_ptr];
`ifdef WB_MISALIGN_CHK_EN
                last_mis  <= mem_mis_p1[rd_ptr];
`endif
            end
            case ({vld_p0, emit})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // ---- output: FIFO head, or last emitted entry when empty ----
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = vld_p1;
    assign bus.wdata     = vld_p1 ? mem_data_p1[rd_ptr] : last_data;
    assign bus.wrd       = vld_p1 ? mem_rd_p1[rd_ptr]   : last_rd;
    assign bus.wopcode   = vld_p1 ? mem_op_p1[rd_ptr]   : last_op;
`ifdef WB_MISALIGN_CHK_EN
    assign bus.misalign  = vld_p1 ? mem_mis_p1[rd_ptr]  : last_mis;
`endif

endmodule
